// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl
//   Programmable serial pattern detector. A pattern configuration (bits,
//   length, overlap mode, frame length) is loaded while idle. A scan then
//   walks a valid-qualified bitstream, pulses 'match' one cycle after every
//   hit, counts hits (saturating), and pulses 'done' when the configured
//   number of bits has been consumed.
//
// Ports
//   CLK          rising-edge clock
//   reset        asynchronous, active-low reset
//   cfg_valid    config write request (honoured in IDLE only)
//   cfg_ready    high in IDLE: config writes are accepted
//   cfg_pattern  pattern; cfg_pattern[len-1] is the first bit in time
//   cfg_len      pattern length; 0 -> 1, values above MAX_LEN -> MAX_LEN
//   cfg_overlap  1 = overlapping matches allowed
//   cfg_frame    bits per frame; 0 = scan until stop
//   start        begin a scan (IDLE only)
//   stop         abort a scan (no done pulse, count retained)
//   bit_valid    qualifier for bit_in
//   bit_in       serial data bit
//   busy         high while scanning
//   match        one-cycle registered match pulse
//   match_count  saturating hit count for the current/last frame
//   done         one-cycle frame-complete pulse
module pattern_scan_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CW      = 16
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic [CW-1:0]                cfg_frame,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         bit_valid,
  input  logic                         bit_in,
  output logic                         busy,
  output logic                         match,
  output logic [CW-1:0]                match_count,
  output logic                         done
);

  localparam int LW = $clog2(MAX_LEN+1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
  localparam logic [LW-1:0] LEN_ONE = LW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // configuration
  logic [MAX_LEN-1:0] pat_reg;
  logic [LW-1:0]      len_reg;
  logic               ovl_reg;
  logic [CW-1:0]      frame_reg;

  // scan datapath
  logic [MAX_LEN-2:0] hist_reg;
  logic [LW-1:0]      fill_reg;
  logic [CW-1:0]      bit_cnt_reg;
  logic [CW-1:0]      count_reg;
  logic               match_reg;

  logic [LW-1:0]      len_clamped;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] len_mask;
  logic [LW-1:0]      len_m1;
  logic               accept;
  logic               hit;
  logic               frame_end;

  // Length clamping is applied once, at load time, so the scan logic can
  // assume 1 <= len_reg <= MAX_LEN.
  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0) begin
      len_clamped = LEN_ONE;
    end else if (cfg_len > LEN_MAX) begin
      len_clamped = LEN_MAX;
    end
  end

  // Newest bit sits at window[0]; the oldest bit of a len-long match is at
  // window[len-1], lining up with cfg_pattern[len-1] being first in time.
  assign window = {hist_reg, bit_in};

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      localparam logic [LW-1:0] IDX = LW'(gi);
      assign len_mask[gi] = (IDX < len_reg);
    end
  endgenerate

  assign len_m1    = len_reg - LEN_ONE;
  assign accept    = (state_reg == SCAN) && bit_valid;
  // fill counts bits already held in history, so len-1 of them plus the
  // incoming bit form a complete window.
  assign hit       = accept && (fill_reg >= len_m1)
                     && (((window ^ pat_reg) & len_mask) == '0);
  assign frame_end = accept && (frame_reg != '0)
                     && ((bit_cnt_reg + CW'(1)) == frame_reg);

  // state register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // next-state logic; stop wins over frame completion
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (frame_end) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // configuration and scan datapath
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      pat_reg     <= MAX_LEN'(2'b01);
      len_reg     <= LW'(2);
      ovl_reg     <= 1'b1;
      frame_reg   <= '0;
      hist_reg    <= '0;
      fill_reg    <= '0;
      bit_cnt_reg <= '0;
      count_reg   <= '0;
      match_reg   <= 1'b0;
    end else begin
      // a hit on a stop or last-of-frame bit still pulses
      match_reg <= hit;

      if (state_reg == IDLE) begin
        if (cfg_valid) begin
          pat_reg   <= cfg_pattern;
          len_reg   <= len_clamped;
          ovl_reg   <= cfg_overlap;
          frame_reg <= cfg_frame;
        end
        if (start) begin
          hist_reg    <= '0;
          fill_reg    <= '0;
          bit_cnt_reg <= '0;
          count_reg   <= '0;
        end
      end

      if (accept) begin
        hist_reg    <= window[MAX_LEN-2:0];
        bit_cnt_reg <= bit_cnt_reg + CW'(1);
        // non-overlap: discard history so the next hit needs len fresh bits
        if (hit && !ovl_reg) begin
          fill_reg <= '0;
        end else if (fill_reg != LEN_MAX) begin
          fill_reg <= fill_reg + LEN_ONE;
        end
        if (hit && (count_reg != '1)) begin
          count_reg <= count_reg + CW'(1);
        end
      end
    end
  end

  assign cfg_ready   = (state_reg == IDLE);
  assign busy        = (state_reg == SCAN);
  assign done        = (state_reg == DONE);
  assign match       = match_reg;
  assign match_count = count_reg;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Testbench for pattern_scan_ctrl: table of frame scenarios plus
// hand-written sequences for stop, mid-scan reset and count saturation.
module tb_pattern_scan_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CW      = 16;
  localparam int LW      = $clog2(MAX_LEN+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               cfg_valid;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               cfg_overlap;
  logic [CW-1:0]      cfg_frame;
  logic               start;
  logic               stop;
  logic               bit_valid;
  logic               bit_in;
  logic               cfg_ready, busy, match, done;
  logic [CW-1:0]      match_count;
  logic               cfg_ready4, busy4, match4, done4;
  logic [3:0]         match_count4;

  pattern_scan_ctrl #(.MAX_LEN(MAX_LEN), .CW(CW)) u_dut (
    .CLK(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_frame(cfg_frame),
    .start(start), .stop(stop), .bit_valid(bit_valid), .bit_in(bit_in),
    .busy(busy), .match(match), .match_count(match_count), .done(done)
  );

  // narrow-counter instance for the saturation check
  pattern_scan_ctrl #(.MAX_LEN(MAX_LEN), .CW(4)) u_dut4 (
    .CLK(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready4), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_frame(cfg_frame[3:0]),
    .start(start), .stop(stop), .bit_valid(bit_valid), .bit_in(bit_in),
    .busy(busy4), .match(match4), .match_count(match_count4), .done(done4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model + scoreboard ----------------
  int          m_len;
  logic [7:0]  m_pat;
  logic        m_ovl;
  logic        m_bits[$];
  int          m_fresh;
  int          m_count;
  logic        exp_q[$];

  task automatic model_config(input logic [7:0] pat, input int len, input logic ovl);
    m_pat = pat;
    m_ovl = ovl;
    if (len == 0) m_len = 1;
    else if (len > MAX_LEN) m_len = MAX_LEN;
    else m_len = len;
  endtask

  task automatic model_start();
    m_bits.delete();
    m_fresh = 0;
    m_count = 0;
  endtask

  // Hit when the last m_len received bits, read back newest-first, equal
  // pattern bits 0..m_len-1, and (non-overlap) all of them arrived after
  // the previous hit.
  task automatic model_accept(input logic b);
    logic h;
    m_bits.push_back(b);
    m_fresh++;
    h = (m_fresh >= m_len);
    if (h) begin
      for (int k = 0; k < m_len; k++) begin
        if (m_bits[m_bits.size()-1-k] != m_pat[k]) h = 1'b0;
      end
    end
    if (h) begin
      if (m_count < 65535) m_count++;
      if (!m_ovl) m_fresh = 0;
    end
    exp_q.push_back(h);
  endtask

  // Drive one accepted bit, then compare match/done/busy after the edge.
  task automatic send_bit(input logic b, input logic exp_done, input logic exp_busy);
    logic e;
    bit_in    = b;
    bit_valid = 1'b1;
    model_accept(b);
    tick();
    bit_valid = 1'b0;
    if (exp_q.size() == 0) begin
      e = 1'b0;
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
    end
    $display("bit=%0b match=%0b exp=%0b done=%0b count=%0d", b, match, e, done, match_count);
    chk("match", match, e);
    chk("done", done, exp_done);
    chk("busy", busy, exp_busy);
  endtask

  task automatic cfg_start(input logic [7:0] pat, input logic [3:0] len,
                           input logic ovl, input logic [15:0] frame);
    cfg_valid   = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_frame   = frame;
    start       = 1'b1;
    model_config(pat, len, ovl);
    model_start();
    tick();
    cfg_valid = 1'b0;
    start     = 1'b0;
    chk("start_cfg_ready", cfg_ready, 0);
    chk("start_busy", busy, 1);
    chk("start_count_clr", match_count, 0);
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    logic [7:0]       pat;
    logic [3:0]       len;
    logic             ovl;
    logic [15:0]      frame;
    string            stream;   // first character is first bit in time
    logic [15:0][1:0] gaps;     // idle cycles inserted before each bit
    int               exp_count;
  } row_t;

  localparam int NROWS = 8;
  row_t rows[NROWS];

  task automatic set_row(input int i, input logic [7:0] pat, input logic [3:0] len,
                         input logic ovl, input logic [15:0] frame,
                         input string s, input int cnt);
    rows[i].pat       = pat;
    rows[i].len       = len;
    rows[i].ovl       = ovl;
    rows[i].frame     = frame;
    rows[i].stream    = s;
    rows[i].gaps      = '0;
    rows[i].exp_count = cnt;
  endtask

  initial begin
    set_row(0, 8'b0000_0001, 4'd2,  1'b1, 16'd4, "0101",     2);
    set_row(1, 8'b1110_0101, 4'd3,  1'b1, 16'd5, "10101",    2);
    set_row(2, 8'b1110_0101, 4'd3,  1'b0, 16'd5, "10101",    1);
    set_row(3, 8'b0000_0001, 4'd2,  1'b1, 16'd4, "0101",     2);
    rows[3].gaps[1] = 2'd3;
    rows[3].gaps[3] = 2'd1;
    set_row(4, 8'hF1,        4'd0,  1'b1, 16'd3, "101",      2);
    set_row(5, 8'hA5,        4'd15, 1'b1, 16'd8, "00100101", 0);
    set_row(6, 8'hA5,        4'd15, 1'b1, 16'd8, "10100101", 1);
    set_row(7, 8'b0000_0110, 4'd4,  1'b0, 16'd7, "0110110",  1);

    reset = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; cfg_frame = '0; start = 1'b0; stop = 1'b0;
    bit_valid = 1'b0; bit_in = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_match", match, 0);
    chk("rst_done", done, 0);
    chk("rst_count", match_count, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // table-driven frames
    for (int r = 0; r < NROWS; r++) begin
      int n;
      n = rows[r].stream.len();
      cfg_start(rows[r].pat, rows[r].len, rows[r].ovl, rows[r].frame);
      for (int i = 0; i < n; i++) begin
        for (int g = 0; g < int'(rows[r].gaps[i]); g++) begin
          bit_valid = 1'b0;
          bit_in    = $urandom_range(0, 1);
          tick();
          chk("gap_match", match, 0);
          chk("gap_busy", busy, 1);
        end
        send_bit(rows[r].stream[i] == "1", i == n-1, i != n-1);
      end
      tick();
      chk("post_done", done, 0);
      chk("post_cfg_ready", cfg_ready, 1);
      chk("post_match", match, 0);
      chk("count_table", match_count, rows[r].exp_count);
      chk("count_model", match_count, m_count);
      $display("row %0d count=%0d expected=%0d", r, match_count, rows[r].exp_count);
    end

    // unbounded frame, '11' pattern, eight 1s then stop; config write mid-scan ignored
    cfg_start(8'b0000_0011, 4'd2, 1'b1, 16'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        cfg_valid   = 1'b1;
        cfg_pattern = 8'h00;
        cfg_frame   = 16'd1;
        chk("scan_cfg_ready", cfg_ready, 0);
      end
      send_bit(1'b1, 1'b0, 1'b1);
      cfg_valid = 1'b0;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_cfg_ready", cfg_ready, 1);
    chk("stop_done", done, 0);
    chk("stop_count", match_count, 7);
    chk("stop_count_model", match_count, m_count);
    tick();
    chk("stop_done_late", done, 0);
    $display("stop sequence count=%0d", match_count);

    // stop coincides with the last bit of the frame which is also a hit
    cfg_start(8'b0000_0001, 4'd2, 1'b1, 16'd2);
    send_bit(1'b0, 1'b0, 1'b1);
    stop = 1'b1;
    send_bit(1'b1, 1'b0, 1'b0);
    stop = 1'b0;
    chk("stopfe_count", match_count, 1);
    chk("stopfe_cfg_ready", cfg_ready, 1);
    tick();
    chk("stopfe_done", done, 0);
    $display("stop+frame_end count=%0d", match_count);

    // saturation: len 1 pattern '1', twenty 1s
    cfg_start(8'b0000_0001, 4'd1, 1'b1, 16'd0);
    for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b0, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("sat_count_cw4", match_count4, 15);
    chk("sat_count_cw16", match_count, 20);
    $display("saturation count4=%0d count16=%0d", match_count4, match_count);

    // reset mid-scan after two matches
    cfg_start(8'b0000_0001, 4'd2, 1'b1, 16'd6);
    send_bit(1'b0, 1'b0, 1'b1);
    send_bit(1'b1, 1'b0, 1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    send_bit(1'b1, 1'b0, 1'b1);
    chk("pre_rst_count", match_count, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_count", match_count, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_match", match, 0);
    chk("midrst_done", done, 0);
    chk("midrst_cfg_ready", cfg_ready, 1);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      tick();
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_match", match, 0);
    end
    bit_valid = 1'b0;
    $display("mid-scan reset count=%0d", match_count);

    // default configuration after reset: '01', len 2, overlap, unbounded
    start = 1'b1;
    model_config(8'b0000_0001, 2, 1'b1);
    model_start();
    tick();
    start = 1'b0;
    chk("dflt_busy", busy, 1);
    send_bit(1'b0, 1'b0, 1'b1);
    send_bit(1'b1, 1'b0, 1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    send_bit(1'b1, 1'b0, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("dflt_count", match_count, 2);
    chk("dflt_busy_end", busy, 0);
    $display("default config count=%0d", match_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
